// File: rtl/dmem_pkg.sv
// Shared types and the init-pattern generator for the parametrised data memory.
package dmem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  localparam int unsigned MAX_DATA_W = 64;

  // Reload value for word i: zeros, or an up-ramp in the lower half and a
  // down-ramp from 0 in the upper half, truncated to data_w bits.
  function automatic logic [MAX_DATA_W-1:0] init_word(
    input int unsigned i,
    input int unsigned depth,
    input int unsigned data_w,
    input int unsigned init_mode
  );
    logic [MAX_DATA_W-1:0] v;
    logic [MAX_DATA_W-1:0] mask;
    if (init_mode == 0) begin
      v = '0;
    end else if (i < depth / 2) begin
      v = MAX_DATA_W'(i);
    end else begin
      v = MAX_DATA_W'(0) - MAX_DATA_W'(i - depth / 2);
    end
    mask = (data_w >= MAX_DATA_W) ? '1
                                  : ((MAX_DATA_W'(1) << data_w) - MAX_DATA_W'(1));
    return v & mask;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: one synchronous write, one registered read, single index.
module dmem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned IDX_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents are only defined once the init walk has run.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register holds its value between reads so rdata never goes X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/param_data_memory.sv
// Parametrised single-port data memory with an init sequencer that walks the array.
module param_data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              init_start,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptr_next;
  logic [IDX_W-1:0]  idx;
  logic              mem_we;
  logic              mem_re;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;

  // Upper address bits alias onto the same word and are deliberately dropped.
  assign idx = addr[IDX_W-1:0];

  generate
    if (ADDR_W > IDX_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];
    end
  endgenerate

  // State, pointer and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_INIT;
      ptr    <= '0;
      busy   <= 1'b1;
      ready  <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      state  <= state_next;
      ptr    <= ptr_next;
      busy   <= (state_next == ST_INIT);
      ready  <= (state_next == ST_IDLE);
      rvalid <= mem_re;
    end
  end

  // Next-state logic and the init-vs-datapath write mux.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_idx    = idx;
    mem_wdata  = wdata;
    case (state)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_idx   = ptr;
        mem_wdata = DATA_W'(init_word(32'(ptr), DEPTH, DATA_W, INIT_MODE));
        ptr_next  = ptr + IDX_W'(1);
        if (ptr == LAST_IDX) begin
          state_next = ST_IDLE;
          ptr_next   = '0;
        end
      end
      ST_IDLE: begin
        if (init_start) begin
          state_next = ST_INIT;
          ptr_next   = '0;
        end else if (req) begin
          mem_we = we;
          mem_re = !we;
        end
      end
      default: begin
        state_next = ST_INIT;
        ptr_next   = '0;
      end
    endcase
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_param_data_memory.sv
// Directed plus randomized checks of param_data_memory against a behavioural model.
module tb_param_data_memory;

  logic        clk;
  logic        reset;

  logic        req0, we0, init0;
  logic [7:0]  addr0, wdata0;
  logic        ready0, rvalid0, busy0;
  logic [7:0]  rdata0;

  logic        req1, we1, init1;
  logic [7:0]  addr1;
  logic [15:0] wdata1;
  logic        ready1, rvalid1, busy1;
  logic [15:0] rdata1;
  logic        ready2, rvalid2, busy2;
  logic [15:0] rdata2;

  int checks = 0;
  int failures = 0;

  logic [7:0] model0 [32];

  param_data_memory dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .init_start(init0), .ready(ready0), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0)
  );

  param_data_memory #(.DATA_W(16), .ADDR_W(8), .DEPTH(64), .INIT_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .init_start(init1), .ready(ready1), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1)
  );

  param_data_memory #(.DATA_W(16), .ADDR_W(8), .DEPTH(64), .INIT_MODE(0)) dut2 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .init_start(init1), .ready(ready2), .rdata(rdata2), .rvalid(rvalid2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected reload value from the pattern rules, in plain integer arithmetic.
  function automatic longint unsigned pat(input int i, input int depth, input int w, input int mode);
    longint unsigned m;
    longint unsigned half;
    m = longint'(1) << w;
    half = longint'(depth / 2);
    if (mode == 0) return 0;
    if (longint'(i) < half) return longint'(i) % m;
    return (m - ((longint'(i) - half) % m)) % m;
  endfunction

  task automatic reload_model0();
    for (int i = 0; i < 32; i++) model0[i] = 8'(pat(i, 32, 8, 1));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit saw_rv;
    logic [7:0] exp_rd;
    int rd_addr [4] = '{16, 17, 31, 15};

    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd3; wdata0 = 8'h00; init0 = 1'b0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'd0; wdata1 = 16'h0000; init1 = 1'b0;
    reload_model0();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_ready", 32'(ready0), 32'd0);
    check("rst_rvalid", 32'(rvalid0), 32'd0);
    check("rst_rdata", 32'(rdata0), 32'd0);
    reset = 1'b0;

    // Init length with a read already pending on addr 3
    n = 0;
    saw_rv = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      n++;
      if (rvalid0) saw_rv = 1'b1;
      if (!busy0) break;
    end
    check("init_busy_cycles", 32'(n), 32'd32);
    check("ready_after_init", 32'(ready0), 32'd1);
    check("no_rvalid_while_busy", 32'(saw_rv), 32'd0);
    tick();
    req0 = 1'b0;
    check("pending_read_rvalid", 32'(rvalid0), 32'd1);
    check("pending_read_rdata", 32'(rdata0), 32'(model0[3]));
    tick();
    check("rvalid_single_pulse", 32'(rvalid0), 32'd0);

    // Back-to-back reads across the ramp boundary
    req0 = 1'b1; we0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addr0 = 8'(rd_addr[k]);
      tick();
      check("b2b_rvalid", 32'(rvalid0), 32'd1);
      check("b2b_rdata", 32'(rdata0), 32'(model0[rd_addr[k]]));
    end
    req0 = 1'b0;
    tick();
    check("b2b_rvalid_end", 32'(rvalid0), 32'd0);
    check("rdata_hold", 32'(rdata0), 32'h0F);

    // Write then immediate read of the same word, plus an aliased read
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd5; wdata0 = 8'hA5;
    tick();
    model0[5] = 8'hA5;
    check("write_no_rvalid", 32'(rvalid0), 32'd0);
    we0 = 1'b0; addr0 = 8'd5;
    tick();
    check("wr_rd_rvalid", 32'(rvalid0), 32'd1);
    check("wr_rd_rdata", 32'(rdata0), 32'hA5);
    addr0 = 8'h25;
    tick();
    check("alias_rdata", 32'(rdata0), 32'hA5);
    req0 = 1'b0;

    // init_start beats a simultaneous write; mid-init init_start is ignored
    init0 = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 8'd6; wdata0 = 8'h77;
    tick();
    init0 = 1'b0; req0 = 1'b0; we0 = 1'b0;
    check("reinit_ready_drop", 32'(ready0), 32'd0);
    check("reinit_busy", 32'(busy0), 32'd1);
    check("reinit_rdata_kept", 32'(rdata0), 32'hA5);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      n++;
      init0 = 1'b0;
      if (!busy0) break;
      if (n == 10) init0 = 1'b1;
    end
    init0 = 1'b0;
    check("reinit_busy_cycles", 32'(n), 32'd32);
    reload_model0();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd5;
    tick();
    check("reinit_rd5", 32'(rdata0), 32'(model0[5]));
    addr0 = 8'd6;
    tick();
    check("reinit_rd6", 32'(rdata0), 32'(model0[6]));
    req0 = 1'b0;

    // Reset in the middle of an init walk restarts it from the beginning
    init0 = 1'b1;
    tick();
    init0 = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    #2;
    check("midinit_rst_busy", 32'(busy0), 32'd1);
    check("midinit_rst_ready", 32'(ready0), 32'd0);
    check("midinit_rst_rdata", 32'(rdata0), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      n++;
      if (!busy0) break;
    end
    check("restart_busy_cycles", 32'(n), 32'd32);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd9;
    tick();
    req0 = 1'b0;
    check("restart_rd9", 32'(rdata0), 32'(model0[9]));

    // Wide, deep instances: ramp and zero fill
    for (int c = 0; c < 200; c++) begin
      if (!busy1 && !busy2) break;
      tick();
    end
    check("wide_ready", 32'(ready1 & ready2), 32'd1);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd33;
    tick();
    check("wide_rvalid", 32'(rvalid1 & rvalid2), 32'd1);
    check("ramp_rd33", 32'(rdata1), 32'(pat(33, 64, 16, 1)));
    check("zero_rd33", 32'(rdata2), 32'(pat(33, 64, 16, 0)));
    addr1 = 8'd31;
    tick();
    check("ramp_rd31", 32'(rdata1), 32'(pat(31, 64, 16, 1)));
    we1 = 1'b1; addr1 = 8'd97; wdata1 = 16'hBEEF;
    tick();
    we1 = 1'b0; addr1 = 8'd33;
    tick();
    req1 = 1'b0;
    check("wide_alias_write", 32'(rdata1), 32'hBEEF);

    // Randomized traffic against the array model
    exp_rd = rdata0;
    check("rand_start_rdata", 32'(exp_rd), 32'(model0[9]));
    for (int i = 0; i < 300; i++) begin
      logic rq, w;
      logic [7:0] a, d;
      rq = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      req0 = rq; we0 = w; addr0 = a; wdata0 = d;
      tick();
      if (rq && !w) exp_rd = model0[a % 32];
      if (rq && w) model0[a % 32] = d;
      check("rand_rvalid", 32'(rvalid0), 32'(rq && !w));
      check("rand_rdata", 32'(rdata0), 32'(exp_rd));
    end
    req0 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
